// File: rtl/mac_vec_accum.sv
// Multi-lane fixed-point MAC engine: LANES feature elements times a broadcast weight,
// accumulated over a job of runtime length, with valid/ready streaming and saturation flags.
module mac_vec_accum #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned LEN_W  = 10,
    parameter bit          SAT    = 1'b1
) (
    input  logic                     clk0,
    input  logic                     clr0_n,
    input  logic                     ena,
    input  logic                     clr,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic                     accumulate,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  ay,
    input  logic [DATA_W-1:0]        az,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   result,
    output logic [LANES-1:0]         sat_flag,
    output logic                     busy
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [LEN_W-1:0]           cnt_q;
    logic                       pv_q;
    logic                       out_valid_q;
    logic signed [PROD_W-1:0]   p_q      [LANES];
    logic signed [ACC_W-1:0]    acc_q    [LANES];
    logic [LANES-1:0]           sat_q;

    logic                       beat_c;
    logic                       out_xfer_c;
    logic                       start_ok_c;
    logic signed [PROD_W-1:0]   prod_c   [LANES];
    logic signed [SUM_W-1:0]    sum_c    [LANES];
    logic signed [ACC_W-1:0]    acc_nx_c [LANES];
    logic [LANES-1:0]           ovf_c;

    // Handshake decode; ena gates every transfer.
    assign in_ready   = ena && (state_q == RUN);
    assign beat_c     = in_valid && in_ready;
    assign out_xfer_c = out_valid_q && out_ready && ena;
    assign start_ok_c = ena && start && (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != IDLE);
    assign sat_flag   = sat_q;

    for (genvar g = 0; g < LANES; g++) begin : g_res
        assign result[g*ACC_W +: ACC_W] = acc_q[g];
    end

    // Per-lane product and one-bit-wider sum; overflow when the two top sum bits disagree.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_c[i]   = PROD_W'($signed(ay[i*DATA_W +: DATA_W])) * PROD_W'($signed(az));
            sum_c[i]    = SUM_W'(acc_q[i]) + SUM_W'(p_q[i]);
            ovf_c[i]    = sum_c[i][ACC_W] ^ sum_c[i][ACC_W-1];
            acc_nx_c[i] = sum_c[i][ACC_W-1:0];
            if (SAT && ovf_c[i]) begin
                acc_nx_c[i] = sum_c[i][ACC_W] ? ACC_MIN : ACC_MAX;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (beat_c && (cnt_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_xfer_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk0 or negedge clr0_n) begin
        if (!clr0_n) begin
            state_q <= IDLE;
        end else if (clr) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Job counter, product pipe, accumulators, flags and the result-valid register.
    always_ff @(posedge clk0 or negedge clr0_n) begin
        if (!clr0_n) begin
            cnt_q       <= '0;
            pv_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= '0;
            for (int i = 0; i < LANES; i++) begin
                p_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else if (clr) begin
            cnt_q       <= '0;
            pv_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= '0;
            for (int i = 0; i < LANES; i++) begin
                p_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else if (ena) begin
            pv_q <= beat_c;
            if (beat_c) begin
                cnt_q <= cnt_q - LEN_W'(1);
                for (int i = 0; i < LANES; i++) begin
                    p_q[i] <= prod_c[i];
                end
            end
            // The product pipe is always empty in IDLE, so a start never races an accumulate.
            if (start_ok_c) begin
                cnt_q <= len;
                if (!accumulate) begin
                    sat_q <= '0;
                    for (int i = 0; i < LANES; i++) begin
                        acc_q[i] <= '0;
                    end
                end
            end else if (pv_q) begin
                sat_q <= sat_q | ovf_c;
                for (int i = 0; i < LANES; i++) begin
                    acc_q[i] <= acc_nx_c[i];
                end
            end
            // Valid rises one cycle after entering DONE, so the last sum has settled into acc.
            if (out_xfer_c) begin
                out_valid_q <= 1'b0;
            end else if (state_q == DONE) begin
                out_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_vec_accum.sv
// Directed bench for mac_vec_accum: a job table on the 40-bit engine plus hand sequences
// for stalls, overflow on 32-bit saturating/wrapping instances, abort and start-in-RUN.
module tb_mac_vec_accum;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LEN_W  = 10;

    logic                     clk0 = 1'b0;
    logic                     clr0_n;
    logic                     ena;
    logic                     clr;
    logic                     start;
    logic [LEN_W-1:0]         len;
    logic                     accumulate;
    logic                     in_valid;
    logic                     out_ready;
    logic [LANES*DATA_W-1:0]  ay;
    logic [DATA_W-1:0]        az;

    logic                     in_ready, out_valid, busy;
    logic [LANES*40-1:0]      result;
    logic [LANES-1:0]         sat_flag;
    logic                     ir_s, ov_s, bz_s;
    logic [LANES*32-1:0]      res_s;
    logic [LANES-1:0]         sf_s;
    logic                     ir_w, ov_w, bz_w;
    logic [LANES*32-1:0]      res_w;
    logic [LANES-1:0]         sf_w;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [LEN_W-1:0]    len;
        logic                acc;
        logic [3:0][15:0]    a;
        logic [15:0]         z;
        logic [3:0][39:0]    r;
    } vec_t;

    vec_t tbl [5];

    mac_vec_accum #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(40), .LEN_W(LEN_W), .SAT(1'b1)) dut (
        .clk0(clk0), .clr0_n(clr0_n), .ena(ena), .clr(clr), .start(start), .len(len),
        .accumulate(accumulate), .in_valid(in_valid), .in_ready(in_ready), .ay(ay), .az(az),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat_flag(sat_flag),
        .busy(busy)
    );

    mac_vec_accum #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(32), .LEN_W(LEN_W), .SAT(1'b1)) dut_sat (
        .clk0(clk0), .clr0_n(clr0_n), .ena(ena), .clr(clr), .start(start), .len(len),
        .accumulate(accumulate), .in_valid(in_valid), .in_ready(ir_s), .ay(ay), .az(az),
        .out_valid(ov_s), .out_ready(out_ready), .result(res_s), .sat_flag(sf_s),
        .busy(bz_s)
    );

    mac_vec_accum #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(32), .LEN_W(LEN_W), .SAT(1'b0)) dut_wrap (
        .clk0(clk0), .clr0_n(clr0_n), .ena(ena), .clr(clr), .start(start), .len(len),
        .accumulate(accumulate), .in_valid(in_valid), .in_ready(ir_w), .ay(ay), .az(az),
        .out_valid(ov_w), .out_ready(out_ready), .result(res_w), .sat_flag(sf_w),
        .busy(bz_w)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500us");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint lane_m(input int i);
        logic signed [39:0] v;
        v = result[i*40 +: 40];
        return longint'(v);
    endfunction

    function automatic vec_t mk(input int l, input bit a, input int a0, input int a1, input int a2,
                                input int a3, input int z, input longint r0, input longint r1,
                                input longint r2, input longint r3);
        vec_t m;
        m.len  = LEN_W'(l);
        m.acc  = a;
        m.a[0] = 16'(a0);
        m.a[1] = 16'(a1);
        m.a[2] = 16'(a2);
        m.a[3] = 16'(a3);
        m.z    = 16'(z);
        m.r[0] = 40'(r0);
        m.r[1] = 40'(r1);
        m.r[2] = 40'(r2);
        m.r[3] = 40'(r3);
        return m;
    endfunction

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({name, "_latency"}, longint'(n), longint'(exp_lat));
    endtask

    // Issue start, feed len back-to-back beats, then wait for the result.
    task automatic run_job(input string name, input vec_t v);
        len        = v.len;
        accumulate = v.acc;
        ay         = v.a;
        az         = v.z;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < int'(v.len); b++) begin
            in_valid = 1'b1;
            chk($sformatf("%s_in_ready_b%0d", name, b), longint'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        wait_out(name, (v.len == '0) ? 1 : 2);
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_out_valid_after"}, longint'(out_valid), 64'd0);
        chk({name, "_busy_after"}, longint'(busy), 64'd0);
    endtask

    task automatic check_main(input string name, input vec_t v);
        logic signed [39:0] e;
        for (int i = 0; i < LANES; i++) begin
            e = v.r[i];
            chk($sformatf("%s_lane%0d", name, i), lane_m(i), longint'(e));
        end
        chk({name, "_sat"}, longint'(sat_flag), 64'd0);
    endtask

    initial begin
        vec_t v;
        logic [7:0] gap_pat;
        int sent;
        int cyc;

        tbl[0] = mk(3, 1'b0, 1, 2, -3, 4, 2, 6, 12, -18, 24);
        tbl[1] = mk(2, 1'b1, 1, 2, -3, 4, 2, 10, 20, -30, 40);
        tbl[2] = mk(1, 1'b0, 1, 2, -3, 4, 2, 2, 4, -6, 8);
        tbl[3] = mk(4, 1'b0, -32768, 32767, -1, 100, -32768,
                    64'sd4294967296, -64'sd4294836224, 64'sd131072, -64'sd13107200);
        tbl[4] = mk(0, 1'b0, 1, 2, 3, 4, 5, 0, 0, 0, 0);

        clr0_n = 1'b0; ena = 1'b1; clr = 1'b0; start = 1'b0; len = '0; accumulate = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; ay = '0; az = '0;
        step();
        step();
        clr0_n = 1'b1;
        step();
        chk("rst_busy", longint'(busy), 64'd0);
        chk("rst_in_ready", longint'(in_ready), 64'd0);
        chk("rst_out_valid", longint'(out_valid), 64'd0);
        chk("rst_result_lane0", lane_m(0), 64'd0);
        chk("rst_sat", longint'(sat_flag), 64'd0);

        // Job table: ordered so that job1 continues from job0's accumulator.
        for (int k = 0; k < 5; k++) begin
            run_job($sformatf("job%0d", k), tbl[k]);
            check_main($sformatf("job%0d", k), tbl[k]);
            release_out($sformatf("job%0d", k));
            chk($sformatf("job%0d_retained_lane3", k), lane_m(3),
                longint'($signed(tbl[k].r[3])));
        end

        // Stalls: in_valid gaps and a two-cycle ena drop mid-RUN, then a held result.
        gap_pat = 8'b1101_1101;
        len = LEN_W'(3); accumulate = 1'b0; ay = tbl[0].a; az = tbl[0].z;
        start = 1'b1;
        step();
        start = 1'b0;
        sent = 0;
        cyc  = 0;
        while (sent < 3 && cyc < 40) begin
            ena      = !(cyc == 3 || cyc == 4);
            in_valid = gap_pat[cyc % 8];
            #1;
            if (!ena) chk($sformatf("stall_in_ready_c%0d", cyc), longint'(in_ready), 64'd0);
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        ena = 1'b1;
        in_valid = 1'b0;
        chk("stall_beats_sent", longint'(sent), 64'd3);
        wait_out("stall", 2);
        for (int h = 0; h < 5; h++) begin
            step();
            chk($sformatf("stall_hold_valid%0d", h), longint'(out_valid), 64'd1);
            chk($sformatf("stall_hold_lane2_%0d", h), lane_m(2), -64'sd18);
        end
        check_main("stall", tbl[0]);
        ena = 1'b0;
        out_ready = 1'b1;
        step();
        chk("stall_ena0_valid", longint'(out_valid), 64'd1);
        chk("stall_ena0_busy", longint'(busy), 64'd1);
        ena = 1'b1;
        release_out("stall");

        // Overflow on the 32-bit instances: 3 * 0x3FFF0001 exceeds the positive range.
        v = mk(3, 1'b0, 32'h7FFF, 0, 0, 0, 32'h7FFF, 0, 0, 0, 0);
        run_job("ovf", v);
        chk("ovf_sat_lane0", longint'(res_s[31:0]), 64'h7FFF_FFFF);
        chk("ovf_sat_lane1", longint'(res_s[63:32]), 64'd0);
        chk("ovf_sat_flag", longint'(sf_s), 64'd1);
        chk("ovf_wrap_lane0", longint'(res_w[31:0]), 64'hBFFD_0003);
        chk("ovf_wrap_flag", longint'(sf_w), 64'd1);
        chk("ovf_wide_lane0", lane_m(0), 64'hBFFD_0003);
        chk("ovf_wide_flag", longint'(sat_flag), 64'd0);
        release_out("ovf");
        v = mk(1, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_job("sticky", v);
        chk("sticky_sat_flag", longint'(sf_s), 64'd1);
        chk("sticky_sat_lane0", longint'(res_s[31:0]), 64'h7FFF_FFFF);
        chk("sticky_wrap_flag", longint'(sf_w), 64'd1);
        release_out("sticky");
        v = mk(0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_job("unstick", v);
        chk("unstick_sat_flag", longint'(sf_s), 64'd0);
        chk("unstick_sat_lane0", longint'(res_s[31:0]), 64'd0);
        release_out("unstick");

        // Synchronous abort after one beat.
        len = LEN_W'(3); accumulate = 1'b0; ay = tbl[0].a; az = tbl[0].z;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("clr_pre_lane0", lane_m(0), 64'd2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy", longint'(busy), 64'd0);
        chk("clr_out_valid", longint'(out_valid), 64'd0);
        chk("clr_lane0", lane_m(0), 64'd0);
        chk("clr_in_ready", longint'(in_ready), 64'd0);

        // Asynchronous reset pulse mid-RUN, checked before the next clock edge.
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("arst_pre_lane1", lane_m(1), 64'd4);
        #2;
        clr0_n = 1'b0;
        #1;
        chk("arst_busy", longint'(busy), 64'd0);
        chk("arst_lane1", lane_m(1), 64'd0);
        chk("arst_out_valid", longint'(out_valid), 64'd0);
        clr0_n = 1'b1;
        step();

        // A start pulse with a different length during RUN must be ignored.
        len = LEN_W'(3); accumulate = 1'b0; ay = tbl[0].a; az = tbl[0].z;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        step();
        start = 1'b1;
        len = LEN_W'(5);
        accumulate = 1'b1;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b0;
        wait_out("midstart", 2);
        check_main("midstart", tbl[0]);
        release_out("midstart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
